// File: rtl/saw_osc.sv
// saw_osc: phase-accumulator sawtooth oscillator.
// A wide phase accumulator advances by the current tuning word on each sample
// tick. The top OUT_W bits form an unsigned ramp. The block also provides:
//   - a valid/ready tuning-word load,
//   - exponential glide toward a newly loaded target,
//   - hard sync on the rising edge of sync_in,
//   - a one-sample wrap pulse for downstream voice logic.
module saw_osc #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  input  logic [3:0]       glide_rate,
  input  logic             sync_in,
  output logic [OUT_W-1:0] saw_out,
  output logic             wrap_out,
  output logic             gliding
);

  typedef enum logic {
    ST_STEADY = 1'b0,
    ST_GLIDE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] cur_ftw_q, cur_ftw_d;
  logic [ACC_W-1:0] tgt_ftw_q, tgt_ftw_d;
  logic             sync_dly_q, sync_dly_d;
  logic             sync_pend_q, sync_pend_d;
  logic             wrap_q, wrap_d;

  // Sync edge detection. A rising edge seen between sample ticks is remembered
  // in sync_pend_q, so a short sync pulse is never lost.
  logic sync_rise;
  logic sync_due;

  // Phase accumulation. The extra top bit is the overflow carry that drives
  // the wrap pulse.
  logic [ACC_W:0] phase_sum;

  // Glide arithmetic.
  // The difference is taken one bit wider so its sign is exact for any pair
  // of unsigned tuning words. The magnitude always fits back into ACC_W bits.
  logic [ACC_W:0]   glide_diff;
  logic             glide_down;
  logic [ACC_W-1:0] glide_mag;
  logic [ACC_W-1:0] glide_shift;
  logic [ACC_W-1:0] glide_step;
  logic             glide_done;
  logic             accept;

  // Edge detect, the phase adder and the glide step size.
  always_comb begin
    sync_rise   = sync_in & ~sync_dly_q;
    sync_due    = sync_pend_q | sync_rise;
    phase_sum   = {1'b0, phase_q} + {1'b0, cur_ftw_q};

    glide_diff  = {1'b0, tgt_ftw_q} - {1'b0, cur_ftw_q};
    glide_down  = glide_diff[ACC_W];
    glide_mag   = glide_down ? (~glide_diff[ACC_W-1:0] + 1'b1)
                             : glide_diff[ACC_W-1:0];

    // The step is a fraction of the remaining distance, floored at one, so
    // the glide always converges.
    glide_shift = glide_mag >> glide_rate;
    glide_step  = (glide_shift == '0) ? {{(ACC_W-1){1'b0}}, 1'b1}
                                      : glide_shift;
    glide_done  = (glide_mag <= glide_step);

    accept      = ftw_valid & (state_q == ST_STEADY);
  end

  // Next state: phase, sync bookkeeping, wrap pulse, tuning word and glide FSM.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cur_ftw_d   = cur_ftw_q;
    tgt_ftw_d   = tgt_ftw_q;
    sync_dly_d  = sync_in;
    sync_pend_d = sync_pend_q;
    wrap_d      = 1'b0;

    // Phase uses cur_ftw_q, which is the value before any glide update or
    // load on this same edge. Sync takes priority over accumulation.
    if (sample_en) begin
      if (sync_due) begin
        phase_d     = '0;
        wrap_d      = 1'b1;
        sync_pend_d = 1'b0;
      end else begin
        phase_d = phase_sum[ACC_W-1:0];
        wrap_d  = phase_sum[ACC_W];
      end
    end else if (sync_rise) begin
      sync_pend_d = 1'b1;
    end

    case (state_q)
      ST_STEADY: begin
        if (accept) begin
          tgt_ftw_d = ftw_in;
          if (glide_rate == 4'd0) begin
            cur_ftw_d = ftw_in;
          end else if (ftw_in != cur_ftw_q) begin
            state_d = ST_GLIDE;
          end
        end
      end
      ST_GLIDE: begin
        // Glide rate is sampled live on every step.
        if (sample_en) begin
          if (glide_done) begin
            cur_ftw_d = tgt_ftw_q;
            state_d   = ST_STEADY;
          end else if (glide_down) begin
            cur_ftw_d = cur_ftw_q - glide_step;
          end else begin
            cur_ftw_d = cur_ftw_q + glide_step;
          end
        end
      end
      default: state_d = ST_STEADY;
    endcase
  end

  // State registers. Reset is asynchronous and also drops any pending sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_STEADY;
      phase_q     <= '0;
      cur_ftw_q   <= '0;
      tgt_ftw_q   <= '0;
      sync_dly_q  <= 1'b0;
      sync_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_ftw_q   <= cur_ftw_d;
      tgt_ftw_q   <= tgt_ftw_d;
      sync_dly_q  <= sync_dly_d;
      sync_pend_q <= sync_pend_d;
      wrap_q      <= wrap_d;
    end
  end

  assign saw_out   = phase_q[ACC_W-1 -: OUT_W];
  assign wrap_out  = wrap_q;
  assign ftw_ready = (state_q == ST_STEADY);
  assign gliding   = (state_q == ST_GLIDE);

endmodule

// File: tb/tb_saw_osc.sv
// tb_saw_osc: self-checking bench for saw_osc.
// It runs, in order:
//   - a directed vector table,
//   - hand-written glide, handshake, sync and reset sequences,
//   - a randomized run checked against an arithmetic reference model.
module tb_saw_osc;
  localparam int     ACC_W = 24;
  localparam int     OUT_W = 11;
  localparam int     SHR   = ACC_W - OUT_W;
  localparam longint MOD   = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [ACC_W-1:0] ftw_in = '0;
  logic             ftw_valid = 1'b0;
  logic             ftw_ready;
  logic [3:0]       glide_rate = 4'd0;
  logic             sync_in = 1'b0;
  logic [OUT_W-1:0] saw_out;
  logic             wrap_out;
  logic             gliding;

  saw_osc #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .ftw_in     (ftw_in),
    .ftw_valid  (ftw_valid),
    .ftw_ready  (ftw_ready),
    .glide_rate (glide_rate),
    .sync_in    (sync_in),
    .saw_out    (saw_out),
    .wrap_out   (wrap_out),
    .gliding    (gliding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit se, input bit v, input logic [ACC_W-1:0] f,
                       input logic [3:0] r, input bit s);
    sample_en  = se;
    ftw_valid  = v;
    ftw_in     = f;
    glide_rate = r;
    sync_in    = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One glide step: move a fraction of the distance, at least 1, landing
  // exactly on the target once the remaining distance fits in one step.
  function automatic longint glide_next(input longint c, input longint t, input int r);
    longint d = t - c;
    longint a = (d < 0) ? -d : d;
    longint s = a >> r;
    if (s < 1) s = 1;
    if (a <= s) return t;
    return (d < 0) ? c - s : c + s;
  endfunction

  // Reference model state.
  longint m_phase, m_cur, m_tgt;
  bit     m_glide, m_sprev, m_pend, m_wrap;

  task automatic model_reset();
    m_phase = 0;
    m_cur   = 0;
    m_tgt   = 0;
    m_glide = 0;
    m_sprev = 0;
    m_pend  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit se, input bit v, input longint f,
                            input int r, input bit s);
    bit     rise  = s && !m_sprev;
    bit     ready = !m_glide;
    longint old_cur = m_cur;
    if (se) begin
      if (m_pend || rise) begin
        m_phase = 0;
        m_wrap  = 1;
        m_pend  = 0;
      end else begin
        m_phase = m_phase + old_cur;
        m_wrap  = (m_phase >= MOD);
        m_phase = m_phase % MOD;
      end
    end else begin
      m_wrap = 0;
      if (rise) m_pend = 1;
    end
    if (m_glide && se) begin
      m_cur = glide_next(m_cur, m_tgt, r);
      if (m_cur == m_tgt) m_glide = 0;
    end
    if (ready && v) begin
      m_tgt = f;
      if (r == 0) m_cur = f;
      else if (f != old_cur) m_glide = 1;
    end
    m_sprev = s;
  endtask

  typedef struct {
    bit               se;
    bit               v;
    logic [ACC_W-1:0] f;
    logic [3:0]       r;
    bit               s;
    int               saw;
    bit               wrap;
    bit               gl;
  } vec_t;

  vec_t   tbl[19];
  longint c, tgt;
  int     nsteps, accepts, acc_cyc, rise_cyc, wraps;
  bit     will_accept;
  bit     r_se, r_v, r_s;
  logic [ACC_W-1:0] r_f;
  logic [3:0]       r_r;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 24'h001000, 4'd0, 1'b0,    0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0,    0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0,    1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0,    1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 24'h000000, 4'd0, 1'b0,    1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 24'h800000, 4'd0, 1'b0,    2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0, 1026, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0,    2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 24'h000000, 4'd0, 1'b0,    2, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b1,    0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b1, 1024, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 24'h000000, 4'd0, 1'b0, 1024, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 24'h000000, 4'd0, 1'b1, 1024, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 24'h000000, 4'd0, 1'b1, 1024, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0,    0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0, 1024, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 24'h000000, 4'd0, 1'b0, 1024, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 24'h000000, 4'd0, 1'b0, 1024, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 24'h000100, 4'd2, 1'b0, 1024, 1'b0, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_saw", saw_out, 0);
    check("reset_wrap", wrap_out, 0);
    check("reset_gliding", gliding, 0);
    check("reset_ready", ftw_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: ramp, max FTW, sync, freeze, and a glide entry.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].se, tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].s);
      tick();
      check($sformatf("tbl%0d_saw", i), saw_out, tbl[i].saw);
      check($sformatf("tbl%0d_wrap", i), wrap_out, tbl[i].wrap);
      check($sformatf("tbl%0d_gliding", i), gliding, tbl[i].gl);
      check($sformatf("tbl%0d_ready", i), ftw_ready, !tbl[i].gl);
    end

    // Glide up from 0 to 0x100 at rate 2.
    c = 0;
    for (int k = 0; k < 100 && c != 256; k++) begin
      drive(1'b1, 1'b0, '0, 4'd2, 1'b0);
      tick();
      c = glide_next(c, 256, 2);
      check("glide_up_cur", dut.cur_ftw_q, c);
      check("glide_up_gliding", gliding, (c != 256));
    end
    check("glide_up_end_ready", ftw_ready, 1);

    // Glide down from 0x100 back to 0.
    drive(1'b0, 1'b1, 24'h000000, 4'd2, 1'b0);
    tick();
    check("glide_dn_start", gliding, 1);
    c = 256;
    for (int k = 0; k < 100 && c != 0; k++) begin
      drive(1'b1, 1'b0, '0, 4'd2, 1'b0);
      tick();
      c = glide_next(c, 0, 2);
      check("glide_dn_cur", dut.cur_ftw_q, c);
      check("glide_dn_ready", ftw_ready, (c == 0));
    end

    // Handshake: keep a new FTW offered throughout a glide.
    c = 0;
    nsteps = 0;
    while (c != 24'h001000) begin
      c = glide_next(c, 24'h001000, 3);
      nsteps++;
    end
    drive(1'b1, 1'b1, 24'h001000, 4'd3, 1'b0);
    tick();
    check("hs_glide_start", gliding, 1);
    ftw_in   = 24'h002000;
    accepts  = 0;
    acc_cyc  = -1;
    rise_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      will_accept = ftw_ready && ftw_valid;
      tick();
      if (will_accept) begin
        accepts++;
        acc_cyc   = k;
        ftw_valid = 1'b0;
      end
      if (rise_cyc < 0 && acc_cyc < 0 && ftw_ready) rise_cyc = k;
    end
    check("hs_accepts", accepts, 1);
    check("hs_ready_rise_cycle", rise_cyc, nsteps - 1);
    check("hs_accept_cycle", acc_cyc, nsteps);
    check("hs_target", dut.tgt_ftw_q, 24'h002000);

    // Hard sync: pulse with sample_en low at saw 700, then hold sync high.
    do_reset();
    drive(1'b0, 1'b1, 24'h002000, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0, 4'd0, 1'b0);
    repeat (700) tick();
    check("sync_pre_saw", saw_out, 700);
    drive(1'b0, 1'b0, '0, 4'd0, 1'b1);
    tick();
    check("sync_pend_wrap", wrap_out, 0);
    drive(1'b0, 1'b0, '0, 4'd0, 1'b0);
    tick();
    tick();
    check("sync_pend_saw", saw_out, 700);
    drive(1'b1, 1'b0, '0, 4'd0, 1'b0);
    tick();
    check("sync_apply_saw", saw_out, 0);
    check("sync_apply_wrap", wrap_out, 1);
    tick();
    check("sync_resume_saw", saw_out, 1);
    check("sync_resume_wrap", wrap_out, 0);
    wraps = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 1'b0, '0, 4'd0, 1'b1);
      tick();
      wraps += int'(wrap_out);
    end
    check("sync_hold_wraps", wraps, 1);
    check("sync_hold_saw", saw_out, 99);

    // Reset mid-glide with a sync pending.
    do_reset();
    drive(1'b0, 1'b1, 24'h400000, 4'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, '0, 4'd0, 1'b0);
    repeat (5) tick();
    check("rst_pre_saw", saw_out, 512);
    drive(1'b0, 1'b1, 24'h100000, 4'd6, 1'b0);
    tick();
    check("rst_pre_gliding", gliding, 1);
    drive(1'b0, 1'b0, '0, 4'd6, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 4'd6, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_saw", saw_out, 0);
    check("rst_async_gliding", gliding, 0);
    check("rst_async_ready", ftw_ready, 1);
    check("rst_async_wrap", wrap_out, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, '0, 4'd0, 1'b0);
      tick();
      check("rst_after_saw", saw_out, 0);
      check("rst_after_wrap", wrap_out, 0);
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 4000; k++) begin
      r_se = ($urandom % 4) != 0;
      r_v  = ($urandom % 8) == 0;
      case ($urandom % 4)
        0:       r_f = ACC_W'($urandom % 4096);
        1:       r_f = 24'h800000;
        default: r_f = ACC_W'($urandom);
      endcase
      r_r = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      r_s = ($urandom % 6) == 0;
      drive(r_se, r_v, r_f, r_r, r_s);
      model_step(r_se, r_v, longint'(r_f), int'(r_r), r_s);
      tick();
      check("rand_saw", saw_out, m_phase >> SHR);
      check("rand_wrap", wrap_out, m_wrap);
      check("rand_gliding", gliding, m_glide);
      check("rand_ready", ftw_ready, !m_glide);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saw_osc.md
# saw_osc

Phase-accumulator sawtooth oscillator feeding the triangle shaper and the other waveform stages of the voice. A sample-rate tick advances a wide phase accumulator by the current frequency tuning word (FTW), and the top bits are presented as an unsigned ramp on `saw_out`. The block adds a valid/ready FTW load with optional exponential glide (portamento), hard sync, and a wrap pulse for downstream sync and voice logic.

## Interface
- `ACC_W`, 24: phase accumulator and FTW width.
- `OUT_W`, 11: ramp output width; the ramp is `phase[ACC_W-1 -: OUT_W]`.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_en`  in  1  sample tick; phase and glide advance only on cycles where it is high.
- `ftw_in`  in  ACC_W  target tuning word.
- `ftw_valid`  in  1  target offered.
- `ftw_ready`  out  1  target accepted on a cycle with `ftw_valid & ftw_ready`.
- `glide_rate`  in  4  0 = jump immediately; larger values give slower glide.
- `sync_in`  in  1  hard sync; acts on its rising edge.
- `saw_out`  out  OUT_W  unsigned ramp, 0 to 2^OUT_W-1.
- `wrap_out`  out  1  one-cycle pulse when the phase overflows or a sync is applied.
- `gliding`  out  1  high while the current FTW differs from the target.

## Operation
- Registers: `phase`, `cur_ftw`, `tgt_ftw` (each ACC_W bits), `state` ∈ {STEADY, GLIDE}, `sync_d`, `sync_pend`, `wrap_out`.
- `ftw_ready` = (state == STEADY). `gliding` = (state == GLIDE).
- Accept in STEADY:
  - `tgt_ftw <= ftw_in`.
  - If `glide_rate == 0`: `cur_ftw <= ftw_in` on the same edge; state stays STEADY.
  - Else if `ftw_in != cur_ftw`: go to GLIDE.
  - Else: no change.
- GLIDE, on each `sample_en`:
  - `diff = tgt_ftw - cur_ftw`, computed signed at ACC_W+1 bits.
  - `step = max(1, |diff| >> glide_rate)`.
  - If `|diff| <= step`: `cur_ftw <= tgt_ftw` and state goes to STEADY.
  - Else: `cur_ftw <= cur_ftw ± step`, moving toward the target.
  - `glide_rate` is sampled live on every step.
- Phase, on `sample_en`:
  - With a sync due: `phase <= 0` and `wrap_out <= 1`.
  - Otherwise: `{carry, phase} <= phase + cur_ftw`, with the addition modulo 2^ACC_W, and `wrap_out <= carry`.
  - The addition uses the `cur_ftw` value before any glide update on the same edge.
- `wrap_out` is 0 on every cycle where `sample_en` is low.
- Sync:
  - `sync_rise = sync_in & ~sync_d`. `sync_d` registers `sync_in` every cycle.
  - A sync is due when `sync_pend | sync_rise`; sync takes priority over accumulation.
  - `sync_rise` without `sync_en` sets `sync_pend`. `sync_pend` clears when the sync is applied.
  - Holding `sync_in` high produces only one sync.
- FTW 0 freezes the phase. FTW 2^(ACC_W-1) gives a two-sample period.

## Timing
- Reset values: `phase`, `cur_ftw`, `tgt_ftw` = 0; `saw_out` = 0; `wrap_out` = 0; `gliding` = 0; `ftw_ready` = 1; `sync_d` = 0; `sync_pend` = 0; state = STEADY.
- Reset mid-glide or mid-sync returns to these values immediately and asynchronously. A pending sync is discarded.
- `saw_out` and `wrap_out` are registered: both update on the same clk edge on which `sample_en` is high, so latency is 1 clk.
- FTW acceptance takes effect on the phase at the next `sample_en` after the accept edge. An accept and a `sample_en` on the same edge use the old `cur_ftw`.
- `ftw_ready` falls on the accept edge when entering GLIDE. It rises on the edge where `cur_ftw` reaches the target; a new accept is possible on the following cycle.
- A sync rising edge coincident with `sample_en` is applied on that edge.

## Test plan
1. **Basic ramp.** After reset, accept FTW 0x001000 with glide 0 and hold `sample_en` = 1.
   - `saw_out` increments by 1 every 2 samples: 0,0,1,1,….
   - `wrap_out` pulses once, after sample 4096, and `saw_out` returns to 0.
2. **Maximum FTW.** FTW 0x800000.
   - `saw_out` alternates 0, 1024, 0, 1024.
   - `wrap_out` is high on every second sample.
3. **Glide up.** From `cur_ftw` 0, accept target 0x000100 with glide_rate 2.
   - `cur_ftw` takes 64, 112, 148, … monotonically, ending exactly at 256.
   - `ftw_ready` is 0 and `gliding` is 1 until the final step; then `ftw_ready` = 1 and `gliding` = 0 on the same edge.
   - A glide down from 256 to 0 mirrors this.
4. **Handshake during glide.** Hold `ftw_valid` with a new FTW throughout a glide.
   - The FTW is not accepted until the cycle after `ftw_ready` returns to 1.
   - Exactly one accept occurs.
5. **Hard sync.**
   - Pulse `sync_in` while `sample_en` = 0 at `saw_out` = 700. At the next `sample_en`: `saw_out` = 0 and `wrap_out` = 1. The ramp then resumes from 0.
   - Hold `sync_in` high for 100 cycles: only a single sync occurs.
6. **Reset mid-operation.** Assert `rst` mid-glide with a sync pending.
   - All outputs go to their reset values with no clk edge.
   - After release, the ramp stays at 0 until a new FTW is accepted.
